prekey_window_ctrl: RTL

- Parametrised successor to the Serpent prekey shift window.
- Accepts user keys of 128, 192 or 256 bits and applies standard Serpent padding to 256 bits.
- Presents the w[i-8], w[i-5], w[i-3], w[i-1] taps to the external prekey generator (phi, XOR, rotate) and accepts each generated word through a valid/ready handshake.
- Packs generated words into 4-word groups for the S-box round-key stage, with backpressure, word/group counting and a done flag.

---
 rtl/prekey_window_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/prekey_window_ctrl.sv
// rtl/prekey_window_ctrl.sv - Serpent prekey shift window with padding, word/group handshakes
//
// Holds the last eight prekey words m1 (newest) .. m8 (oldest), loaded from a
// padded user key. The external generator reads taps and word_index, and
// returns w[i] over a valid/ready handshake. Every four accepted words are
// presented as one group to the S-box round-key stage.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   key_in, key_len user key (right-aligned) and length code (0=128,1=192,2/3=256)
//   load            start/restart a schedule from key_in/key_len
//   gen_taps        {w[i-8], w[i-5], w[i-3], w[i-1]} = {m8, m5, m3, m1}
//   word_index      index i of the next word to generate
//   word_in/valid   generated word and its valid
//   word_ready      window accepts word_in this cycle
//   group_out       {m1, m2, m3, m4}
//   group_valid     group_out holds a complete group
//   group_ready     consumer takes group_out
//   group_index     index of the current group
//   busy, done      schedule running / all groups delivered
module prekey_window_ctrl #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 132,
  parameter int IDX_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [8*WORD_W-1:0]   key_in,
  input  logic [1:0]            key_len,
  input  logic                  load,
  output logic [4*WORD_W-1:0]   gen_taps,
  output logic [IDX_W-1:0]      word_index,
  input  logic [WORD_W-1:0]     word_in,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic [4*WORD_W-1:0]   group_out,
  output logic                  group_valid,
  input  logic                  group_ready,
  output logic [5:0]            group_index,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [IDX_W-1:0] NUM_WORDS_I = IDX_W'(NUM_WORDS);
  localparam logic [5:0]       LAST_GROUP  = 6'(NUM_WORDS / 4 - 1);

  state_t            state;
  logic [WORD_W-1:0] win      [1:8];
  logic [WORD_W-1:0] pad_word [0:7];
  logic [3:0]        key_words;
  logic              word_xfer;
  logic              group_xfer;

  // Padding: keep the first key_words words, put a single 1 in bit 0 of the
  // word just past the key, zero everything above it.
  always_comb begin
    case (key_len)
      2'd0:    key_words = 4'd4;
      2'd1:    key_words = 4'd6;
      default: key_words = 4'd8;
    endcase
    for (int w = 0; w < 8; w++) begin
      if (4'(w) < key_words)
        pad_word[w] = key_in[w*WORD_W +: WORD_W];
      else if (4'(w) == key_words)
        pad_word[w] = WORD_W'(1);
      else
        pad_word[w] = '0;
    end
  end

  // A pending group that is not being taken blocks new words, so the group
  // registers m1..m4 are never overwritten before they are consumed.
  assign word_ready = (state == RUN) && (word_index < NUM_WORDS_I) &&
                      !(group_valid && !group_ready);
  assign word_xfer  = word_valid && word_ready;
  assign group_xfer = group_valid && group_ready;

  assign gen_taps  = {win[8], win[5], win[3], win[1]};
  assign group_out = {win[1], win[2], win[3], win[4]};
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      word_index  <= '0;
      group_index <= '0;
      group_valid <= 1'b0;
      for (int k = 1; k <= 8; k++) win[k] <= '0;
    end else if (load) begin
      // Load overrides any word or group transfer in the same cycle.
      state       <= RUN;
      word_index  <= '0;
      group_index <= '0;
      group_valid <= 1'b0;
      for (int k = 1; k <= 8; k++) win[k] <= pad_word[8-k];
    end else begin
      if (word_xfer) begin
        win[1] <= word_in;
        for (int k = 2; k <= 8; k++) win[k] <= win[k-1];
        word_index <= word_index + IDX_W'(1);
      end

      if (group_xfer) begin
        group_index <= group_index + 6'd1;
        if (group_index == LAST_GROUP)
          state <= DONE;
      end

      // The fourth word of a group sets valid; this cannot collide with a
      // held group because such a group would have blocked word_ready.
      if (word_xfer && (word_index[1:0] == 2'b11))
        group_valid <= 1'b1;
      else if (group_xfer)
        group_valid <= 1'b0;
    end
  end

endmodule
